// File: rtl/arbitro_memoria.sv
// arbitro_memoria: two-way (CPU/DMA) arbiter for the single memory port.
// Registered grants, round-robin on conflicts, optional DMA burst limit.
//
// Ports:
//   Reloj, Reiniciar            clock, synchronous active-low reset
//   ReqCPU/ReqDMA               bus requests (held for whole ownership)
//   DirX/DatoEscX/EscX          requester address, write data, write flag
//   GntCPU/GntDMA               registered grants (one-hot or idle)
//   ListoCPU/ListoDMA           transfer complete for the owner
//   DatoLeido                   read data pass-through
//   MemDir/MemDatoEsc/MemEsc    muxed memory address, data, write strobe
//   MemSel                      memory access active
//   MemListo/MemDatoLeido       memory completion and read data
//
// Build option: define ARBITRO_RAFAGA_EN to enable the burst limit
// (RAFAGA_MAX transfers per grant while the other side waits).
module arbitro_memoria #(
    parameter int unsigned ANCHO_DIR  = 16,
    parameter int unsigned ANCHO_DATO = 16,
    parameter int unsigned RAFAGA_MAX = 8
) (
    input  logic                  Reloj,
    input  logic                  Reiniciar,
    input  logic                  ReqCPU,
    input  logic                  ReqDMA,
    input  logic [ANCHO_DIR-1:0]  DirCPU,
    input  logic [ANCHO_DIR-1:0]  DirDMA,
    input  logic [ANCHO_DATO-1:0] DatoEscCPU,
    input  logic [ANCHO_DATO-1:0] DatoEscDMA,
    input  logic                  EscCPU,
    input  logic                  EscDMA,
    output logic                  GntCPU,
    output logic                  GntDMA,
    output logic                  ListoCPU,
    output logic                  ListoDMA,
    output logic [ANCHO_DATO-1:0] DatoLeido,
    output logic [ANCHO_DIR-1:0]  MemDir,
    output logic [ANCHO_DATO-1:0] MemDatoEsc,
    output logic                  MemEsc,
    output logic                  MemSel,
    input  logic                  MemListo,
    input  logic [ANCHO_DATO-1:0] MemDatoLeido
);

    if (RAFAGA_MAX < 1) begin : g_rafaga_invalida
        $error("arbitro_memoria: RAFAGA_MAX must be >= 1");
    end

    typedef enum logic [1:0] {
        LIBRE    = 2'd0,
        SERV_CPU = 2'd1,
        SERV_DMA = 2'd2
    } estado_t;

    // Ultimo encoding: which side owned the bus last.
    localparam logic ULT_CPU = 1'b0;
    localparam logic ULT_DMA = 1'b1;

    estado_t estado_q;
    logic    gnt_cpu_q;
    logic    gnt_dma_q;
    logic    ultimo_q;

    logic sel_cpu_d;
    logic sel_dma_d;
    logic liberar_d;
    logic gana_cpu_d;

`ifdef ARBITRO_RAFAGA_EN
    localparam int unsigned ANCHO_CUENTA = $clog2(RAFAGA_MAX) + 1;
    localparam logic [ANCHO_CUENTA-1:0] CUENTA_FIN =
        ANCHO_CUENTA'(RAFAGA_MAX - 1);

    logic [ANCHO_CUENTA-1:0] cuenta_q;
    logic                    listo_own_d;
    logic                    limite_d;
    logic                    otra_req_d;
`endif

    // An access is live only while the owner still requests.
    assign sel_cpu_d = gnt_cpu_q & ReqCPU;
    assign sel_dma_d = gnt_dma_q & ReqDMA;

    assign GntCPU    = gnt_cpu_q;
    assign GntDMA    = gnt_dma_q;
    assign MemSel    = sel_cpu_d | sel_dma_d;
    assign ListoCPU  = MemListo & sel_cpu_d;
    assign ListoDMA  = MemListo & sel_dma_d;
    assign DatoLeido = MemDatoLeido;

    always_comb begin
        MemDir     = '0;
        MemDatoEsc = '0;
        MemEsc     = 1'b0;
        unique case (1'b1)
            gnt_cpu_q: begin
                MemDir     = DirCPU;
                MemDatoEsc = DatoEscCPU;
                MemEsc     = EscCPU & ReqCPU;
            end
            gnt_dma_q: begin
                MemDir     = DirDMA;
                MemDatoEsc = DatoEscDMA;
                MemEsc     = EscDMA & ReqDMA;
            end
            default: ;
        endcase
    end

    // Conflict from LIBRE goes to the side that did not own last.
    assign gana_cpu_d = ReqCPU & (~ReqDMA | (ultimo_q == ULT_DMA));

`ifdef ARBITRO_RAFAGA_EN
    assign listo_own_d = ListoCPU | ListoDMA;
    assign limite_d    = listo_own_d & (cuenta_q == CUENTA_FIN);
    assign otra_req_d  = gnt_cpu_q ? ReqDMA : ReqCPU;
`endif

    always_comb begin
        liberar_d = (gnt_cpu_q & ~ReqCPU) | (gnt_dma_q & ~ReqDMA);
`ifdef ARBITRO_RAFAGA_EN
        if (limite_d && otra_req_d) begin
            liberar_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge Reloj) begin
        if (!Reiniciar) begin
            estado_q  <= LIBRE;
            gnt_cpu_q <= 1'b0;
            gnt_dma_q <= 1'b0;
            ultimo_q  <= ULT_DMA;
`ifdef ARBITRO_RAFAGA_EN
            cuenta_q  <= '0;
`endif
        end else begin
            unique case (estado_q)
                LIBRE: begin
                    if (gana_cpu_d) begin
                        estado_q  <= SERV_CPU;
                        gnt_cpu_q <= 1'b1;
`ifdef ARBITRO_RAFAGA_EN
                        cuenta_q  <= '0;
`endif
                    end else if (ReqDMA) begin
                        estado_q  <= SERV_DMA;
                        gnt_dma_q <= 1'b1;
`ifdef ARBITRO_RAFAGA_EN
                        cuenta_q  <= '0;
`endif
                    end
                end
                SERV_CPU, SERV_DMA: begin
                    if (liberar_d) begin
                        estado_q  <= LIBRE;
                        gnt_cpu_q <= 1'b0;
                        gnt_dma_q <= 1'b0;
                        ultimo_q  <= (estado_q == SERV_DMA) ? ULT_DMA
                                                            : ULT_CPU;
                    end
`ifdef ARBITRO_RAFAGA_EN
                    // Limit hit with nobody waiting: restart the burst.
                    if (listo_own_d) begin
                        cuenta_q <= limite_d ? '0
                                             : cuenta_q + ANCHO_CUENTA'(1);
                    end
`endif
                end
                default: begin
                    estado_q  <= LIBRE;
                    gnt_cpu_q <= 1'b0;
                    gnt_dma_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
